ps2_scancode_translator: RTL and testbench

- Sits between the PS/2 frame decoder and the keystroke FIFO.
- Consumes raw Set-2 scan-code bytes and their valid strobe.
- Tracks E0/F0/E1 prefixes and modifier state.
- Emits one ASCII byte with a one-cycle strobe per printable or control key press; the FIFO stores ASCII instead of raw codes.

---
 rtl/ps2_scancode_translator.sv | 248 ++++++++++++++++++++++++
 tb/tb_ps2_scancode_translator.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_translator.sv
// PS/2 Set-2 scan-code to ASCII translator.
// Tracks prefixes and modifiers; one-cycle strobe per printable/control make.
module ps2_scancode_translator #(
  parameter int PAUSE_SKIP_LEN = 7,
  parameter bit ENABLE_CTRL    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_in,
  input  logic       code_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  output logic [3:0] mods,
  output logic       seq_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       letter;
    logic [7:0] lo;
    logic [7:0] hi;
  } key_t;

  localparam logic [7:0] SKIP_INIT = 8'(PAUSE_SKIP_LEN);

  state_t     state_q, state_d;
  logic [7:0] skip_q, skip_d;
  logic       valid_q, accept;
  logic       ev_make, ev_brk, ev_ext, set_err;
  logic       emit;
  logic [7:0] emit_char;
  logic       lshift, rshift, lctrl, rctrl, lalt, ralt;
  logic       caps, caps_held;
  logic       shift, ctrl;
  key_t       key;

  function automatic key_t ltr(input logic [7:0] c);
    return '{hit: 1'b1, letter: 1'b1, lo: c, hi: c - 8'h20};
  endfunction

  function automatic key_t sym(input logic [7:0] l, input logic [7:0] h);
    return '{hit: 1'b1, letter: 1'b0, lo: l, hi: h};
  endfunction

  function automatic key_t lookup(input logic [7:0] c);
    key_t k;
    k = '0;
    case (c)
      8'h1C: k = ltr(8'h61);
      8'h32: k = ltr(8'h62);
      8'h21: k = ltr(8'h63);
      8'h23: k = ltr(8'h64);
      8'h24: k = ltr(8'h65);
      8'h2B: k = ltr(8'h66);
      8'h34: k = ltr(8'h67);
      8'h33: k = ltr(8'h68);
      8'h43: k = ltr(8'h69);
      8'h3B: k = ltr(8'h6A);
      8'h42: k = ltr(8'h6B);
      8'h4B: k = ltr(8'h6C);
      8'h3A: k = ltr(8'h6D);
      8'h31: k = ltr(8'h6E);
      8'h44: k = ltr(8'h6F);
      8'h4D: k = ltr(8'h70);
      8'h15: k = ltr(8'h71);
      8'h2D: k = ltr(8'h72);
      8'h1B: k = ltr(8'h73);
      8'h2C: k = ltr(8'h74);
      8'h3C: k = ltr(8'h75);
      8'h2A: k = ltr(8'h76);
      8'h1D: k = ltr(8'h77);
      8'h22: k = ltr(8'h78);
      8'h35: k = ltr(8'h79);
      8'h1A: k = ltr(8'h7A);
      8'h45: k = sym(8'h30, 8'h29);
      8'h16: k = sym(8'h31, 8'h21);
      8'h1E: k = sym(8'h32, 8'h40);
      8'h26: k = sym(8'h33, 8'h23);
      8'h25: k = sym(8'h34, 8'h24);
      8'h2E: k = sym(8'h35, 8'h25);
      8'h36: k = sym(8'h36, 8'h5E);
      8'h3D: k = sym(8'h37, 8'h26);
      8'h3E: k = sym(8'h38, 8'h2A);
      8'h46: k = sym(8'h39, 8'h28);
      8'h4E: k = sym(8'h2D, 8'h5F);
      8'h55: k = sym(8'h3D, 8'h2B);
      8'h54: k = sym(8'h5B, 8'h7B);
      8'h5B: k = sym(8'h5D, 8'h7D);
      8'h4C: k = sym(8'h3B, 8'h3A);
      8'h52: k = sym(8'h27, 8'h22);
      8'h41: k = sym(8'h2C, 8'h3C);
      8'h49: k = sym(8'h2E, 8'h3E);
      8'h4A: k = sym(8'h2F, 8'h3F);
      8'h0E: k = sym(8'h60, 8'h7E);
      8'h5D: k = sym(8'h5C, 8'h7C);
      8'h29: k = sym(8'h20, 8'h20);
      8'h5A: k = sym(8'h0D, 8'h0D);
      8'h66: k = sym(8'h08, 8'h08);
      8'h0D: k = sym(8'h09, 8'h09);
      8'h76: k = sym(8'h1B, 8'h1B);
      default: k = '0;
    endcase
    return k;
  endfunction

  assign accept = code_valid & ~valid_q;
  assign shift  = lshift | rshift;
  assign ctrl   = lctrl | rctrl;
  assign mods   = {caps, lalt | ralt, ctrl, shift};
  assign key    = lookup(code_in);

  // Prefix sequencer: classify each accepted byte into make/break events
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    set_err = 1'b0;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            code_in == 8'hE0: state_d = S_EXT;
            code_in == 8'hF0: state_d = S_BRK;
            code_in == 8'hE1: begin
              state_d = S_SKIP;
              skip_d  = SKIP_INIT;
            end
            code_in == 8'h00, code_in == 8'hAA,
            code_in == 8'hFA, code_in == 8'hFE,
            code_in == 8'hFF: state_d = S_IDLE;
            default: ev_make = 1'b1;
          endcase
        end
        S_EXT: begin
          unique case (1'b1)
            code_in == 8'hF0: state_d = S_EXT_BRK;
            code_in == 8'hE0: set_err = 1'b1;
            default: begin
              ev_make = 1'b1;
              ev_ext  = 1'b1;
              state_d = S_IDLE;
            end
          endcase
        end
        S_BRK, S_EXT_BRK: begin
          unique case (1'b1)
            code_in == 8'hE0: begin
              set_err = 1'b1;
              state_d = S_EXT;
            end
            code_in == 8'hF0: set_err = 1'b1;
            default: begin
              ev_brk  = 1'b1;
              ev_ext  = (state_q == S_EXT_BRK);
              state_d = S_IDLE;
            end
          endcase
        end
        S_SKIP: begin
          if (skip_q <= 8'd1) begin
            skip_d  = 8'd0;
            state_d = S_IDLE;
          end else begin
            skip_d = skip_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Character selection for make events
  always_comb begin
    emit      = 1'b0;
    emit_char = 8'h00;
    if (ev_make && ev_ext) begin
      if (code_in == 8'h5A) begin
        emit      = 1'b1;
        emit_char = 8'h0D;
      end else if (code_in == 8'h4A) begin
        emit      = 1'b1;
        emit_char = 8'h2F;
      end
    end else if (ev_make && key.hit) begin
      emit = 1'b1;
      if (key.letter) begin
        if (ENABLE_CTRL && ctrl) emit_char = key.lo - 8'h60;
        else if (shift ^ caps)   emit_char = key.hi;
        else                     emit_char = key.lo;
      end else begin
        emit_char = shift ? key.hi : key.lo;
      end
    end
  end

  // State, modifier and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      skip_q      <= 8'd0;
      valid_q     <= 1'b0;
      ascii_out   <= 8'h00;
      ascii_valid <= 1'b0;
      seq_error   <= 1'b0;
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      lctrl       <= 1'b0;
      rctrl       <= 1'b0;
      lalt        <= 1'b0;
      ralt        <= 1'b0;
      caps        <= 1'b0;
      caps_held   <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      valid_q     <= code_valid;
      ascii_valid <= emit;
      if (emit) ascii_out <= emit_char;
      if (set_err) seq_error <= 1'b1;
      if (ev_make || ev_brk) begin
        unique case (1'b1)
          !ev_ext && code_in == 8'h12: lshift <= ev_make;
          !ev_ext && code_in == 8'h59: rshift <= ev_make;
          !ev_ext && code_in == 8'h14: lctrl  <= ev_make;
          ev_ext  && code_in == 8'h14: rctrl  <= ev_make;
          !ev_ext && code_in == 8'h11: lalt   <= ev_make;
          ev_ext  && code_in == 8'h11: ralt   <= ev_make;
          !ev_ext && code_in == 8'h58: begin
            if (ev_brk) begin
              caps_held <= 1'b0;
            end else if (!caps_held) begin
              caps      <= ~caps;
              caps_held <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_translator.sv
// Scoreboard bench for ps2_scancode_translator.
// Two instances: default parameters and ENABLE_CTRL=0.
module tb_ps2_scancode_translator;

  typedef struct {
    logic [7:0] c;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code_in = 8'h00;
  logic       code_valid = 1'b0;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic [3:0] mods;
  logic       seq_error;
  logic [7:0] code_in0 = 8'h00;
  logic       code_valid0 = 1'b0;
  logic [7:0] ascii_out0;
  logic       ascii_valid0;
  logic [3:0] mods0;
  logic       seq_error0;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  exp_t q0[$];

  ps2_scancode_translator dut (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in), .code_valid(code_valid),
    .ascii_out(ascii_out), .ascii_valid(ascii_valid),
    .mods(mods), .seq_error(seq_error)
  );

  ps2_scancode_translator #(.ENABLE_CTRL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .code_in(code_in0), .code_valid(code_valid0),
    .ascii_out(ascii_out0), .ascii_valid(ascii_valid0),
    .mods(mods0), .seq_error(seq_error0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && ascii_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_emit: got %02h at cycle %0d, none expected",
                 ascii_out, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (ascii_out !== e.c || cyc != e.cyc) begin
          errors++;
          $display("FAIL emit: got %02h at cycle %0d, expected %02h at cycle %0d",
                   ascii_out, cyc, e.c, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ascii_valid0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL unexpected_emit_noctrl: got %02h, none expected",
                 ascii_out0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        if (ascii_out0 !== e.c || cyc != e.cyc) begin
          errors++;
          $display("FAIL emit_noctrl: got %02h at %0d, expected %02h at %0d",
                   ascii_out0, cyc, e.c, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic send_x(input bit sel, input logic [7:0] b, input int hold,
                        input bit has_exp, input logic [7:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) begin
      code_in0 = b;
      code_valid0 = 1'b1;
    end else begin
      code_in = b;
      code_valid = 1'b1;
    end
    if (has_exp) begin
      e.c = c;
      e.cyc = cyc + 1;
      if (sel) q0.push_back(e);
      else     q.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1;
    code_valid = 1'b0;
    code_valid0 = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    send_x(1'b0, b, 1, 1'b0, 8'h00);
  endtask

  task automatic send_e(input logic [7:0] b, input logic [7:0] c);
    send_x(1'b0, b, 1, 1'b1, c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check("rst_ascii_out", ascii_out, 8'h00);
    check("rst_ascii_valid", {7'd0, ascii_valid}, 8'h00);
    check("rst_mods", {4'd0, mods}, 8'h00);
    check("rst_seq_error", {7'd0, seq_error}, 8'h00);
    rst_n = 1'b1;

    send_e(8'h1C, 8'h61);
    send(8'hF0); send(8'h1C);
    send(8'hAA); send(8'h05);

    send(8'h12);
    check("mods_shift_on", {4'd0, mods}, 8'h01);
    send_e(8'h1C, 8'h41);
    send_e(8'h16, 8'h21);
    send_e(8'h4E, 8'h5F);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    check("mods_shift_off", {4'd0, mods}, 8'h00);

    send(8'h58); send(8'h58);
    send(8'hF0); send(8'h58);
    check("mods_caps", {4'd0, mods}, 8'h08);
    send_e(8'h1C, 8'h41);
    send_e(8'h16, 8'h31);
    send(8'h12);
    send_e(8'h15, 8'h71);
    send_e(8'h45, 8'h29);
    send(8'hF0); send(8'h12);
    send(8'h59);
    send_e(8'h1A, 8'h7A);
    send(8'hF0); send(8'h59);

    send(8'h14);
    check("mods_ctrl", {4'd0, mods}, 8'h0A);
    send_e(8'h21, 8'h03);
    send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h11);
    check("mods_ralt", {4'd0, mods}, 8'h0C);
    send_e(8'h1C, 8'h41);
    send(8'hE0); send(8'hF0); send(8'h11);
    check("mods_ralt_off", {4'd0, mods}, 8'h08);

    send_x(1'b1, 8'h14, 1, 1'b0, 8'h00);
    check("noctrl_mods", {4'd0, mods0}, 8'h02);
    send_x(1'b1, 8'h21, 1, 1'b1, 8'h63);

    send(8'hE1); send(8'h14); send(8'h77);
    send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0); send(8'h77);
    send_e(8'h16, 8'h31);
    check("seq_error_after_pause", {7'd0, seq_error}, 8'h00);
    send(8'hE0); send_e(8'h5A, 8'h0D);
    send(8'hE0); send(8'h75);
    send(8'hE0); send_e(8'h4A, 8'h2F);

    send_x(1'b0, 8'h29, 5, 1'b1, 8'h20);

    send(8'hE0); send(8'hF0); send(8'hF0);
    check("seq_error_set", {7'd0, seq_error}, 8'h01);
    send(8'h1C);
    check("seq_error_sticky", {7'd0, seq_error}, 8'h01);

    send(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst_ascii_out", ascii_out, 8'h00);
    check("midrst_mods", {4'd0, mods}, 8'h00);
    check("midrst_seq_error", {7'd0, seq_error}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_e(8'h1C, 8'h61);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 8'(q.size()), 8'h00);
    check("queue0_drained", 8'(q0.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
